seven_seg_scan_ctrl: RTL and testbench

SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

---
 rtl/seven_seg_scan_ctrl.sv | 115 +++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed 4-digit seven-segment scanner with dark guard gaps between
// digits and frame-aligned double-buffered display updates.
module seven_seg_scan_ctrl #(
  parameter int ON_CYCLES    = 1000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  output logic        load_ready,
  input  logic [15:0] value,
  input  logic [3:0]  blank_in,
  input  logic [3:0]  dp_in,
  output logic [3:0]  nibble_out,
  input  logic [6:0]  seg_in,
  output logic [6:0]  seg_out,
  output logic        dp_n,
  output logic [3:0]  dig_sel_n,
  output logic        frame_start
);

  localparam int         NUM_DIG    = 4;
  localparam logic [15:0] ON_LAST    = 16'(ON_CYCLES - 1);
  localparam logic [15:0] GUARD_LAST = 16'(GUARD_CYCLES - 1);

  typedef enum logic {S_GUARD, S_ON} state_t;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  blank;
    logic [3:0]  dp;
  } disp_t;

  localparam disp_t DISP_RST = '{value: 16'h0000, blank: 4'hF, dp: 4'h0};

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_idx, w_idx_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  disp_t       r_disp, r_pend;
  logic        r_pend_valid;

  logic        w_apply;
  logic        w_load_acc;
  logic [NUM_DIG-1:0] w_lit;
  logic        w_any_lit;

  // Frame boundary: last guard cycle before digit 0 lights up.
  assign w_apply    = (r_state == S_GUARD) && (r_cnt == GUARD_LAST) && (r_idx == 2'd0);
  assign load_ready = !r_pend_valid;
  assign w_load_acc = load && load_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 16'd1;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_GUARD: begin
        if (r_cnt == GUARD_LAST) begin
          w_state_nxt = S_ON;
          w_cnt_nxt   = 16'd0;
        end
      end
      S_ON: begin
        if (r_cnt == ON_LAST) begin
          w_state_nxt = S_GUARD;
          w_cnt_nxt   = 16'd0;
          w_idx_nxt   = r_idx + 2'd1;
        end
      end
      default: begin
        w_state_nxt = S_GUARD;
        w_cnt_nxt   = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_GUARD;
      r_idx   <= 2'd0;
      r_cnt   <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Apply takes priority; a load can only land when pend is empty anyway.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_disp       <= DISP_RST;
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
    end else if (w_apply && r_pend_valid) begin
      r_disp       <= r_pend;
      r_pend_valid <= 1'b0;
    end else if (w_load_acc) begin
      r_pend       <= '{value: value, blank: blank_in, dp: dp_in};
      r_pend_valid <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_DIG; g++) begin : g_dig
    assign w_lit[g] = (r_state == S_ON) && (r_idx == 2'(g)) && !r_disp.blank[g];
  end

  assign w_any_lit   = |w_lit;
  assign dig_sel_n   = ~w_lit;
  assign seg_out     = w_any_lit ? seg_in : 7'h7F;
  assign dp_n        = !(w_any_lit && r_disp.dp[r_idx]);
  assign nibble_out  = r_disp.value[{r_idx, 2'b00} +: 4];
  assign frame_start = (r_state == S_ON) && (r_idx == 2'd0) && (r_cnt == 16'd0);

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench: expected per-cycle display outputs are queued as loads are
// driven and compared against the scanner at each falling clock edge.
module tb_seven_seg_scan_ctrl;

  localparam int ON   = 4;
  localparam int GRD  = 2;
  localparam int SLOT = ON + GRD;
  localparam int FR   = 4 * SLOT;

  logic        clk, resetn, load, load_ready;
  logic [15:0] value;
  logic [3:0]  blank_in, dp_in, nibble_out, dig_sel_n;
  logic [6:0]  seg_in, seg_out;
  logic        dp_n, frame_start;

  int n_chk  = 0;
  int n_pass = 0;
  int viol   = 0;
  int cyc;

  typedef struct {
    int          c;
    logic [12:0] e;
  } sb_t;
  sb_t sb[$];

  seven_seg_scan_ctrl #(.ON_CYCLES(ON), .GUARD_CYCLES(GRD)) dut (
    .clk(clk), .resetn(resetn), .load(load), .load_ready(load_ready),
    .value(value), .blank_in(blank_in), .dp_in(dp_in), .nibble_out(nibble_out),
    .seg_in(seg_in), .seg_out(seg_out), .dp_n(dp_n), .dig_sel_n(dig_sel_n),
    .frame_start(frame_start)
  );

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  assign seg_in = hex7(nibble_out);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or negedge resetn)
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // Expected {dig_sel_n, seg_out, dp_n, frame_start} for cycle c after release.
  function automatic logic [12:0] exp_out(input int c, input logic [15:0] v,
                                          input logic [3:0] b, input logic [3:0] d);
    logic [3:0] sel = 4'hF;
    logic [6:0] seg = 7'h7F;
    logic       dpn = 1'b1;
    logic       fs  = 1'b0;
    int p, k;
    if (c >= GRD) begin
      p  = (c - GRD) % FR;
      k  = p / SLOT;
      fs = (p == 0);
      if ((p % SLOT) < ON && !b[k]) begin
        sel[k] = 1'b0;
        seg    = hex7(v[4*k +: 4]);
        dpn    = !d[k];
      end
    end
    return {sel, seg, dpn, fs};
  endfunction

  task automatic push_range(input int c0, input int c1, input logic [15:0] v,
                            input logic [3:0] b, input logic [3:0] d);
    sb_t s;
    for (int c = c0; c <= c1; c++) begin
      s.c = c;
      s.e = exp_out(c, v, b, d);
      sb.push_back(s);
    end
  endtask

  task automatic push_frame(input int f, input logic [15:0] v,
                            input logic [3:0] b, input logic [3:0] d);
    push_range(GRD + FR*f, GRD + FR*f + FR - 1, v, b, d);
  endtask

  task automatic wait_cyc(input int n);
    @(negedge clk);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic drive(input logic l, input logic [15:0] v,
                       input logic [3:0] b, input logic [3:0] d);
    load = l; value = v; blank_in = b; dp_in = d;
  endtask

  always @(negedge clk) begin
    sb_t s;
    if (resetn) begin
      if ($countones(~dig_sel_n) > 1) viol++;
      if (sb.size() > 0 && sb[0].c == cyc) begin
        s = sb.pop_front();
        chk($sformatf("out_c%0d", cyc), {19'd0, dig_sel_n, seg_out, dp_n, frame_start}, {19'd0, s.e});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0;
    drive(1'b0, 16'h0, 4'h0, 4'h0);
    #3;
    chk("rst_out", {19'd0, dig_sel_n, seg_out, dp_n, frame_start}, {19'd0, 4'hF, 7'h7F, 1'b1, 1'b0});
    chk("rst_rdy", {31'd0, load_ready}, 32'd1);
    chk("rst_nib", {28'd0, nibble_out}, 32'd0);

    push_range(0, GRD - 1, 16'h0, 4'hF, 4'h0);
    push_frame(0, 16'h0, 4'hF, 4'h0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // Single load, shown from frame 1.
    wait_cyc(10);
    chk("rdy_pre", {31'd0, load_ready}, 32'd1);
    drive(1'b1, 16'h1234, 4'h0, 4'b0100);
    wait_cyc(11);
    drive(1'b0, 16'h0, 4'h0, 4'h0);
    chk("rdy_pend", {31'd0, load_ready}, 32'd0);
    wait_cyc(20);
    push_frame(1, 16'h1234, 4'h0, 4'b0100);
    wait_cyc(26);
    chk("rdy_applied", {31'd0, load_ready}, 32'd1);

    // Back-to-back loads: second is refused, retry after the next frame start.
    wait_cyc(34);
    drive(1'b1, 16'hAAAA, 4'h0, 4'h0);
    wait_cyc(35);
    drive(1'b1, 16'hBBBB, 4'h0, 4'h0);
    chk("rdy_b2b", {31'd0, load_ready}, 32'd0);
    wait_cyc(36);
    drive(1'b0, 16'h0, 4'h0, 4'h0);
    wait_cyc(40);
    push_frame(2, 16'hAAAA, 4'h0, 4'h0);
    wait_cyc(55);
    drive(1'b1, 16'hBBBB, 4'h0, 4'h0);
    wait_cyc(56);
    drive(1'b0, 16'h0, 4'h0, 4'h0);
    wait_cyc(60);
    push_frame(3, 16'hBBBB, 4'h0, 4'h0);

    // Load held on the apply edge while pend is full: refused.
    wait_cyc(80);
    drive(1'b1, 16'h5678, 4'h0, 4'b1000);
    wait_cyc(81);
    drive(1'b0, 16'h0, 4'h0, 4'h0);
    wait_cyc(97);
    drive(1'b1, 16'h9999, 4'h0, 4'hF);
    chk("rdy_apply_full", {31'd0, load_ready}, 32'd0);
    push_frame(4, 16'h5678, 4'h0, 4'b1000);
    wait_cyc(98);
    drive(1'b0, 16'h0, 4'h0, 4'h0);
    chk("rdy_after_apply", {31'd0, load_ready}, 32'd1);
    push_frame(5, 16'h5678, 4'h0, 4'b1000);

    // Load on the apply edge with pend empty: waits a full frame.
    wait_cyc(121);
    drive(1'b1, 16'hFFFF, 4'b1010, 4'b0001);
    chk("rdy_apply_empty", {31'd0, load_ready}, 32'd1);
    wait_cyc(122);
    drive(1'b0, 16'h0, 4'h0, 4'h0);
    chk("rdy_late_load", {31'd0, load_ready}, 32'd0);
    push_frame(6, 16'hFFFF, 4'b1010, 4'b0001);
    wait_cyc(147);
    chk("rdy_f6", {31'd0, load_ready}, 32'd1);

    // Pending data that the reset must discard.
    wait_cyc(150);
    drive(1'b1, 16'h4321, 4'h0, 4'h0);
    wait_cyc(151);
    drive(1'b0, 16'h0, 4'h0, 4'h0);

    // Reset mid-digit-2: outputs dark with no clock edge.
    wait_cyc(159);
    chk("dig2_lit", {28'd0, dig_sel_n}, {28'd0, 4'b1011});
    #2 resetn = 1'b0;
    #1;
    chk("arst_out", {19'd0, dig_sel_n, seg_out, dp_n, frame_start}, {19'd0, 4'hF, 7'h7F, 1'b1, 1'b0});
    chk("arst_rdy", {31'd0, load_ready}, 32'd1);
    chk("arst_nib", {28'd0, nibble_out}, 32'd0);
    chk("sb_left", sb.size(), FR - 1 - (159 - GRD - 6*FR));
    sb.delete();

    push_range(0, GRD - 1, 16'h0, 4'hF, 4'h0);
    push_frame(0, 16'h0, 4'hF, 4'h0);
    push_frame(1, 16'h0, 4'hF, 4'h0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    wait_cyc(GRD + 2*FR + 2);

    chk("sb_drained", sb.size(), 0);
    chk("onehot", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
